// File: rtl/branch_sequencer_if.sv
// Control bundle between the core sequencer logic and branch_sequencer.
// master: the side issuing requests/instructions; slave: the sequencer.
interface branch_sequencer_if #(
  parameter int DEPTH_W = 8
);
  logic [1:0]         req_state;
  logic               halt_req;
  logic [3:0]         instruction;
  logic [1:0]         state;
  logic               core_enable;
  logic               pc_write;
  logic [DEPTH_W-1:0] depth;
  logic               depth_overflow;
  logic [15:0]        branch_cycles;

  modport master (
    output req_state, halt_req, instruction,
    input  state, core_enable, pc_write, depth, depth_overflow, branch_cycles
  );

  modport slave (
    input  req_state, halt_req, instruction,
    output state, core_enable, pc_write, depth, depth_overflow, branch_cycles
  );
endinterface

// File: rtl/branch_sequencer.sv
// Branch sequencer: arbitrates between core execution, bracket-matching
// branch skipping (CBF/CBB nesting), single-cycle stalls and halt.
// Optional macro SEQ_PERF_CNT_EN compiles in the branch_cycles counter;
// without it branch_cycles is tied to zero.
module branch_sequencer #(
  parameter int         DEPTH_W = 8,
  parameter logic [3:0] OP_CBF  = 4'h6,
  parameter logic [3:0] OP_CBB  = 4'h7
) (
  input logic               clock,
  input logic               reset_n,
  branch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_CORE   = 2'b00,
    ST_BRANCH = 2'b01,
    ST_STALL  = 2'b10,
    ST_HALT   = 2'b11
  } state_e;

  localparam logic [1:0] REQ_BRANCH = 2'b01;
  localparam logic [1:0] REQ_STALL  = 2'b10;

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d;

  // Next-state and depth tracking; all outputs come from registers below.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_CORE: begin
        if (bus.halt_req) begin
          state_d = ST_HALT;
        end else if (bus.req_state == REQ_BRANCH) begin
          state_d = ST_BRANCH;
          depth_d = DEPTH_W'(1);
        end else if (bus.req_state == REQ_STALL) begin
          state_d = ST_STALL;
        end
      end
      ST_BRANCH: begin
        // halt_req/req_state are deliberately ignored while skipping.
        if (bus.instruction == OP_CBF) begin
          if (depth_q == '1) begin
            ovf_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            depth_d = depth_q + DEPTH_W'(1);
          end
        end else if (bus.instruction == OP_CBB) begin
          if (depth_q > DEPTH_W'(1)) begin
            depth_d = depth_q - DEPTH_W'(1);
          end else begin
            // Matching bracket found: resume at the following instruction.
            depth_d = '0;
            state_d = ST_CORE;
          end
        end
      end
      ST_STALL: state_d = ST_CORE;
      default:  state_d = ST_HALT;
    endcase
  end

  // State, depth and sticky overflow registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_CORE;
      depth_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] bc_q, bc_d;

  // Saturating count of cycles spent away from core execution (BRANCH/STALL).
  always_comb begin
    bc_d = bc_q;
    if ((state_q == ST_BRANCH || state_q == ST_STALL) && bc_q != 16'hFFFF) begin
      bc_d = bc_q + 16'd1;
    end
  end

  // Performance counter register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bc_q <= '0;
    end else begin
      bc_q <= bc_d;
    end
  end

  assign bus.branch_cycles = bc_q;
`else
  assign bus.branch_cycles = 16'd0;
`endif

  assign bus.state          = state_q;
  assign bus.core_enable    = (state_q == ST_CORE);
  assign bus.pc_write       = (state_q == ST_BRANCH) || (state_q == ST_STALL);
  assign bus.depth          = depth_q;
  assign bus.depth_overflow = ovf_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: one 8-bit-depth instance for the
// main sequences and one 2-bit-depth instance for the overflow case.
module tb_branch_sequencer;

  localparam logic [1:0] S_CORE = 2'b00, S_BRANCH = 2'b01, S_STALL = 2'b10, S_HALT = 2'b11;
  localparam logic [1:0] R_CORE = 2'b00, R_BRANCH = 2'b01, R_STALL = 2'b10, R_RSVD = 2'b11;
  localparam logic [3:0] OP_INC = 4'h1, OP_DEC = 4'h2, OP_CBF = 4'h6, OP_CBB = 4'h7, OP_HLT = 4'hF;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  branch_sequencer_if #(.DEPTH_W(8)) ifa ();
  branch_sequencer_if #(.DEPTH_W(2)) ifb ();

  branch_sequencer #(.DEPTH_W(8), .OP_CBF(OP_CBF), .OP_CBB(OP_CBB)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(ifa)
  );
  branch_sequencer #(.DEPTH_W(2), .OP_CBF(OP_CBF), .OP_CBB(OP_CBB)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(ifb)
  );

  typedef struct {
    bit          sel;
    string       tag;
    logic [1:0]  st;
    logic [7:0]  dp;
    logic        ov;
    logic [15:0] bc;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [15:0] perf(input int n);
`ifdef SEQ_PERF_CNT_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic [1:0] rs, input logic hr, input logic [3:0] ins);
    ifa.req_state = rs; ifa.halt_req = hr; ifa.instruction = ins;
  endtask

  task automatic drv_b(input logic [1:0] rs, input logic hr, input logic [3:0] ins);
    ifb.req_state = rs; ifb.halt_req = hr; ifb.instruction = ins;
  endtask

  task automatic exp_a(input string tag, input logic [1:0] st, input logic [7:0] dp,
                       input logic ov, input int n);
    exp_t e;
    e.sel = 1'b0; e.tag = tag; e.st = st; e.dp = dp; e.ov = ov; e.bc = perf(n);
    sb.push_back(e);
  endtask

  task automatic exp_b(input string tag, input logic [1:0] st, input logic [7:0] dp,
                       input logic ov, input int n);
    exp_t e;
    e.sel = 1'b1; e.tag = tag; e.st = st; e.dp = dp; e.ov = ov; e.bc = perf(n);
    sb.push_back(e);
  endtask

  // Advance one clock, then drain the scoreboard against the registered outputs.
  task automatic tick();
    exp_t e;
    logic exp_ce, exp_pw;
    @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      exp_ce = (e.st == S_CORE);
      exp_pw = (e.st == S_BRANCH) || (e.st == S_STALL);
      if (!e.sel) begin
        chk({e.tag, ".state"}, 32'(ifa.state),          32'(e.st));
        chk({e.tag, ".ce"},    32'(ifa.core_enable),    32'(exp_ce));
        chk({e.tag, ".pcw"},   32'(ifa.pc_write),       32'(exp_pw));
        chk({e.tag, ".depth"}, 32'(ifa.depth),          32'(e.dp));
        chk({e.tag, ".ovf"},   32'(ifa.depth_overflow), 32'(e.ov));
        chk({e.tag, ".bc"},    32'(ifa.branch_cycles),  32'(e.bc));
      end else begin
        chk({e.tag, ".state"}, 32'(ifb.state),          32'(e.st));
        chk({e.tag, ".ce"},    32'(ifb.core_enable),    32'(exp_ce));
        chk({e.tag, ".pcw"},   32'(ifb.pc_write),       32'(exp_pw));
        chk({e.tag, ".depth"}, 32'(ifb.depth),          32'(e.dp));
        chk({e.tag, ".ovf"},   32'(ifb.depth_overflow), 32'(e.ov));
        chk({e.tag, ".bc"},    32'(ifb.branch_cycles),  32'(e.bc));
      end
    end
  endtask

  initial begin
    drv_a(R_CORE, 1'b0, OP_INC);
    drv_b(R_CORE, 1'b0, OP_INC);

    // Reset state of both instances.
    reset_n = 1'b0;
    exp_a("rst_a", S_CORE, 8'd0, 1'b0, 0);
    exp_b("rst_b", S_CORE, 8'd0, 1'b0, 0);
    tick();
    reset_n = 1'b1;
    exp_a("post_rst", S_CORE, 8'd0, 1'b0, 0);
    tick();

    // Branch skip: INC, CBF, DEC, CBB, CBB; DEC step also tries halt/stall.
    drv_a(R_BRANCH, 1'b0, OP_INC); exp_a("br_enter", S_BRANCH, 8'd1, 1'b0, 0); tick();
    drv_a(R_CORE,   1'b0, OP_INC); exp_a("br_inc",   S_BRANCH, 8'd1, 1'b0, 1); tick();
    drv_a(R_CORE,   1'b0, OP_CBF); exp_a("br_cbf",   S_BRANCH, 8'd2, 1'b0, 2); tick();
    drv_a(R_STALL,  1'b1, OP_DEC); exp_a("br_dec",   S_BRANCH, 8'd2, 1'b0, 3); tick();
    drv_a(R_CORE,   1'b0, OP_CBB); exp_a("br_cbb1",  S_BRANCH, 8'd1, 1'b0, 4); tick();
    drv_a(R_CORE,   1'b0, OP_CBB); exp_a("br_cbb2",  S_CORE,   8'd0, 1'b0, 5); tick();

    // Single stall cycle, then reserved request leaves CORE unchanged.
    drv_a(R_STALL, 1'b0, OP_INC); exp_a("stall",      S_STALL, 8'd0, 1'b0, 5); tick();
    drv_a(R_CORE,  1'b0, OP_INC); exp_a("stall_exit", S_CORE,  8'd0, 1'b0, 6); tick();
    drv_a(R_RSVD,  1'b0, OP_INC); exp_a("rsvd_req",   S_CORE,  8'd0, 1'b0, 6); tick();

    // Halt beats a simultaneous branch request and is absorbing.
    drv_a(R_BRANCH, 1'b1, OP_CBF); exp_a("halt_enter", S_HALT, 8'd0, 1'b0, 6); tick();
    for (int i = 0; i < 10; i++) begin
      drv_a((i % 2 == 0) ? R_BRANCH : R_STALL, 1'b0, OP_CBF);
      exp_a("halt_hold", S_HALT, 8'd0, 1'b0, 6);
      tick();
    end
    reset_n = 1'b0;
    drv_a(R_CORE, 1'b0, OP_INC); exp_a("halt_rst", S_CORE, 8'd0, 1'b0, 0); tick();
    reset_n = 1'b1;

    // HLT inside BRANCH is skipped; reset mid-branch at depth 2.
    drv_a(R_BRANCH, 1'b0, OP_INC); exp_a("br2_enter", S_BRANCH, 8'd1, 1'b0, 0); tick();
    drv_a(R_CORE,   1'b1, OP_HLT); exp_a("br2_hlt",   S_BRANCH, 8'd1, 1'b0, 1); tick();
    drv_a(R_CORE,   1'b0, OP_CBF); exp_a("br2_cbf",   S_BRANCH, 8'd2, 1'b0, 2); tick();
    reset_n = 1'b0;
    drv_a(R_CORE,   1'b0, OP_CBB); exp_a("br2_rst",   S_CORE,   8'd0, 1'b0, 0); tick();
    reset_n = 1'b1;
    exp_a("br2_release", S_CORE, 8'd0, 1'b0, 0); tick();

    // 2-bit depth: CBF at depth 3 saturates, flags overflow and halts.
    drv_b(R_BRANCH, 1'b0, OP_INC); exp_b("ov_enter", S_BRANCH, 8'd1, 1'b0, 0); tick();
    drv_b(R_CORE,   1'b0, OP_CBF); exp_b("ov_cbf1",  S_BRANCH, 8'd2, 1'b0, 1); tick();
    drv_b(R_CORE,   1'b0, OP_CBF); exp_b("ov_cbf2",  S_BRANCH, 8'd3, 1'b0, 2); tick();
    drv_b(R_CORE,   1'b0, OP_CBF); exp_b("ov_cbf3",  S_HALT,   8'd3, 1'b1, 3); tick();
    drv_b(R_BRANCH, 1'b0, OP_CBB); exp_b("ov_sticky", S_HALT,  8'd3, 1'b1, 3); tick();
    reset_n = 1'b0;
    exp_b("ov_rst", S_CORE, 8'd0, 1'b0, 0); tick();
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 The module SHALL have parameter DEPTH_W, default 8, meaning the width of the bracket-nesting depth counter.
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The module SHALL have port req_state, input, 2 bits: the next-state request from the core control bundle; CORE_S=00, BRANCH_S=01, STALL_S=10, 11 reserved.
REQ-005 The module SHALL have port halt_req, input, 1 bit: the halt flag from the core control bundle.
REQ-006 The module SHALL have port instruction, input, 4 bits: the op_code currently fetched; CBF and CBB are the only codes it decodes.
REQ-007 The module SHALL have port state, output, 2 bits: the current sequencer state; CORE=00, BRANCH=01, STALL=10, HALT=11.
REQ-008 The module SHALL have port core_enable, output, 1 bit: high when the core control bundle may commit writes.
REQ-009 The module SHALL have port pc_write, output, 1 bit: the PC advance enable while not in CORE; OR-ed externally with the bundle pc_write gated by core_enable.
REQ-010 The module SHALL have port depth, output, DEPTH_W bits: the current nesting depth.
REQ-011 The module SHALL have port depth_overflow, output, 1 bit: a sticky error flag.
REQ-012 The module SHALL have port branch_cycles, output, 16 bits: a performance counter (see Configuration).

Function
REQ-013 In CORE, the block SHALL drive core_enable=1 and pc_write=0.
REQ-014 In CORE, when halt_req=1, the next state SHALL be HALT; halt_req has priority over req_state.
REQ-015 In CORE, when req_state=BRANCH_S, the next state SHALL be BRANCH and depth SHALL load 1.
REQ-016 In CORE, when req_state=STALL_S, the next state SHALL be STALL.
REQ-017 In CORE, when req_state=CORE_S or 11, the state SHALL remain CORE.
REQ-018 In BRANCH, the block SHALL drive core_enable=0 and pc_write=1 every cycle.
REQ-019 In BRANCH, instruction=CBF SHALL increment depth by 1.
REQ-020 In BRANCH, instruction=CBB with depth>1 SHALL decrement depth by 1.
REQ-021 In BRANCH, instruction=CBB with depth==1 SHALL set depth to 0, and the next state SHALL be CORE, so execution resumes at the instruction after the matching CBB.
REQ-022 In BRANCH, all other op_codes, including HLT, SHALL be skipped with no effect on depth; halt_req and req_state SHALL be ignored.
REQ-023 In BRANCH, CBF with depth equal to all-ones SHALL leave depth unchanged, set depth_overflow, and make the next state HALT.
REQ-024 STALL SHALL last exactly one cycle with core_enable=0 and pc_write=1, then return to CORE unconditionally.
REQ-025 HALT SHALL be absorbing until reset, with core_enable=0 and pc_write=0.
REQ-026 depth_overflow SHALL stay set until reset.
REQ-027 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-028 While reset_n=0 at a clock edge, the block SHALL set state=CORE, depth=0, depth_overflow=0 and branch_cycles=0.
REQ-029 Reset SHALL take priority over every transition, including in the middle of BRANCH or in HALT.
REQ-030 Outputs SHALL be core_enable=1 and pc_write=0 in the first cycle after reset is released.

Configuration
REQ-031 With SEQ_PERF_CNT_EN defined, branch_cycles SHALL increment by 1 each cycle spent in BRANCH or STALL and saturate at 16'hFFFF.
REQ-032 Without SEQ_PERF_CNT_EN, branch_cycles SHALL be tied to 0 and no counter logic SHALL be compiled in.

Verification
REQ-033 The bench SHALL drive req_state=BRANCH_S in CORE, then instructions INC, CBF, DEC, CBB, CBB -> depth 1,1,2,2,1,0; state returns to CORE after the second CBB; pc_write=1 for 5 cycles.
REQ-034 The bench SHALL drive req_state=STALL_S for one cycle -> exactly one STALL cycle with core_enable=0 and pc_write=1, then CORE.
REQ-035 The bench SHALL drive halt_req=1 together with req_state=BRANCH_S -> HALT; the state holds for 10 cycles with pc_write=0; reset_n=0 returns CORE.
REQ-036 With DEPTH_W=2, the bench SHALL enter BRANCH and then drive CBF x3 -> depth 1,2,3,3; depth_overflow=1; state=HALT.
REQ-037 The bench SHALL assert reset_n=0 at depth=2 in the middle of BRANCH -> next cycle state=CORE, depth=0; HLT fetched during BRANCH does not halt.
REQ-038 With SEQ_PERF_CNT_EN defined, the bench SHALL run the REQ-033 sequence plus one stall -> branch_cycles=6; without the macro, branch_cycles=0.
